// File: rtl/seq_mul_ctrl.sv
// Sequential shift-and-add unsigned multiplier with valid/ready handshakes on both sides.
// Optional macro SEQ_MUL_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are zero.
module seq_mul_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_reg, state_next;

  logic [WIDTH-1:0]   mcand_reg, mplier_reg, acc_hi_reg, acc_lo_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] out_reg;

  logic [WIDTH-1:0]   add_a, add_b, add_sum;
  logic [NSLICE:0]    carry;
  logic [WIDTH-1:0]   acc_hi_shift, acc_lo_shift, mplier_shift;
  logic [2*WIDTH-1:0] product;
  logic               run_last;

  assign add_a    = acc_hi_reg;
  assign add_b    = mplier_reg[0] ? mcand_reg : '0;
  assign carry[0] = 1'b0;

  // Each 4-bit slice resolves its carries in parallel; only slice carries ripple.
  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_cla
      logic [3:0] a, b, g, p;
      logic [4:0] c;
      assign a    = add_a[4*gi +: 4];
      assign b    = add_b[4*gi +: 4];
      assign g    = a & b;
      assign p    = a | b;
      assign c[0] = carry[gi];
      assign c[1] = g[0] | (p[0] & c[0]);
      assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c[0]);
      assign add_sum[4*gi +: 4] = a ^ b ^ c[3:0];
      assign carry[gi+1] = c[4];
    end
  endgenerate

  // The adder carry-out becomes the new top bit of the accumulator.
  assign acc_hi_shift = {carry[NSLICE], add_sum[WIDTH-1:1]};
  assign acc_lo_shift = {add_sum[0], acc_lo_reg[WIDTH-1:1]};
  assign mplier_shift = {1'b0, mplier_reg[WIDTH-1:1]};

`ifdef SEQ_MUL_EARLY_EXIT_EN
  logic [CW-1:0] shamt;
  assign run_last = (cnt_reg == LAST_STEP) || (mplier_shift == '0);
  assign shamt    = LAST_STEP - cnt_reg;
  assign product  = {acc_hi_shift, acc_lo_shift} >> shamt;
`else
  assign run_last = (cnt_reg == LAST_STEP);
  assign product  = {acc_hi_shift, acc_lo_shift};
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (run_last)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
    busy      = (state_reg != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      cnt_reg    <= '0;
      out_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          mcand_reg  <= in1;
          mplier_reg <= in2;
          acc_hi_reg <= '0;
          acc_lo_reg <= '0;
          cnt_reg    <= '0;
        end
        RUN: begin
          acc_hi_reg <= acc_hi_shift;
          acc_lo_reg <= acc_lo_shift;
          mplier_reg <= mplier_shift;
          cnt_reg    <= cnt_reg + 1'b1;
          if (run_last) out_reg <= product;
        end
        default: ;
      endcase
    end
  end

  assign out = out_reg;

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Randomized bench for seq_mul_ctrl: products, latency and handshakes against an arithmetic model.
// Build with SEQ_MUL_EARLY_EXIT_EN defined to check the early-exit latency model instead.
module tb_seq_mul_ctrl;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]   in1, in2;
  logic [2*W-1:0] out;
  int total = 0;
  int bad = 0;

  seq_mul_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected number of RUN cycles for a given multiplier.
  function automatic int run_cycles(input logic [W-1:0] b);
`ifdef SEQ_MUL_EARLY_EXIT_EN
    int r = 0;
    for (int i = 0; i < W; i++) if (b[i]) r = i + 1;
    return (r == 0) ? 1 : r;
`else
    return W;
`endif
  endfunction

  // One complete operation starting from IDLE; hold keeps in_valid high with junk operands.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall, input bit hold);
    logic [2*W-1:0] exp = (2*W)'(a) * (2*W)'(b);
    int lat = 1;
    bit saw_ready = 1'b0;
    in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b0;
    check("ready_idle", in_ready, 1);
    tick();
    while (!out_valid && lat < 100) begin
      if (in_ready) saw_ready = 1'b1;
      in_valid = hold;
      in1 = W'($urandom); in2 = W'($urandom);
      tick();
      lat++;
    end
    check("latency", lat, run_cycles(b) + 1);
    check("ready_busy", saw_ready, 0);
    check("product", out, exp);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_out", out, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("back_idle", {busy, out_valid, in_ready}, 3'b001);
    check("idle_hold", out, exp);
    $display("op %h*%h -> %h lat=%0d stall=%0d hold=%0d", a, b, out, lat, stall, hold);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in1 = '0; in2 = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_state", {busy, out_valid, in_ready}, 3'b001);
    check("rst_out", out, 0);

    run_op(8'hFF, 8'hFF, 0, 1'b0);
    run_op(8'h0D, 8'h0B, 5, 1'b0);
    run_op(8'hC3, 8'h01, 0, 1'b0);
    run_op(8'h5A, 8'h00, 0, 1'b0);
    run_op(8'h77, 8'h80, 2, 1'b1);

    // Abort in RUN cycle 4.
    in1 = 8'hAA; in2 = 8'h55; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_run_state", {busy, out_valid, in_ready}, 3'b001);
    check("abort_run_out", out, 0);
    run_op(8'h03, 8'h05, 0, 1'b0);

    // Abort while stalled in DONE, with out_ready raised in the same cycle as rst.
    in1 = 8'h12; in2 = 8'h34; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    check("done_reached", out_valid, 1);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    check("abort_done_state", {busy, out_valid, in_ready}, 3'b001);
    check("abort_done_out", out, 0);

    for (int n = 0; n < 400; n++)
      run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_mul_ctrl.md
SEQ_MUL_CTRL -- requirements
Module: seq_mul_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal values are multiples of 4, minimum 4.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit, the reset; synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit, meaning the operand pair is valid.
REQ-005 SHALL have port in_ready, output, 1 bit, meaning the block accepts operands.
REQ-006 SHALL have port in1, input, WIDTH bits, the unsigned multiplicand.
REQ-007 SHALL have port in2, input, WIDTH bits, the unsigned multiplier.
REQ-008 SHALL have port out_valid, output, 1 bit, meaning the product is valid.
REQ-009 SHALL have port out_ready, input, 1 bit, meaning downstream accepts the product.
REQ-010 SHALL have port out, output, 2*WIDTH bits, the unsigned product in1*in2.
REQ-011 SHALL have port busy, output, 1 bit, which is high whenever the state is not IDLE.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE, and an accept occurs on in_valid&in_ready at a clock edge.
REQ-014 On accept, SHALL capture in1/in2, clear the accumulator and step counter, and go to RUN.
REQ-015 Each RUN cycle SHALL add the multiplicand to the upper WIDTH accumulator bits if the current multiplier LSB is 1, else add 0.
REQ-016 Each RUN cycle SHALL then shift {carry, acc_hi, acc_lo} right by 1 and shift the multiplier right by 1.
REQ-017 SHALL perform the RUN-cycle addition with WIDTH/4 4-bit carry-lookahead slices (generate=a&b, propagate=a|b), with slice carry chained and carry-in 0.
REQ-018 The adder SHALL be WIDTH+1 bits wide, with its carry-out kept as the shift-in bit, so no product bit is lost.
REQ-019 Without early exit, SHALL execute exactly WIDTH RUN cycles, then go to DONE.
REQ-020 Total latency SHALL be WIDTH+1 cycles from the accept edge to the first cycle with out_valid=1.
REQ-021 In DONE, SHALL assert out_valid=1 and keep out stable until out_valid&out_ready at a clock edge, then go to IDLE.
REQ-022 out_ready held low SHALL stall in DONE indefinitely, with no change to out.
REQ-023 in_valid asserted while busy SHALL be ignored; the operands are not captured.
REQ-024 Back-to-back throughput SHALL be one result per WIDTH+2 cycles, because the block returns to IDLE for 1 cycle before the next accept.
REQ-025 out SHALL hold the last product while in IDLE, and holds 0 after reset until the first result.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, clear the accumulator, multiplier register and counter, and set out=0, out_valid=0, busy=0, in_ready=1 in the following cycle.
REQ-027 rst in RUN or DONE SHALL abort the operation; the aborted product is never presented.
REQ-028 rst SHALL take priority over accept and over output handshake in the same cycle.

Configuration
REQ-029 Macro SEQ_MUL_EARLY_EXIT_EN SHALL compile in early termination.
REQ-030 With SEQ_MUL_EARLY_EXIT_EN defined, RUN SHALL end after the current cycle when the shifted multiplier register becomes all-zero.
REQ-031 With SEQ_MUL_EARLY_EXIT_EN defined, the remaining (WIDTH - steps) right shifts SHALL be applied in one barrel shift on entry to DONE.
REQ-032 With SEQ_MUL_EARLY_EXIT_EN defined, RUN SHALL last max(1, index of MSB set in in2 + 1) cycles.
REQ-033 With SEQ_MUL_EARLY_EXIT_EN defined, out values SHALL be identical to the fixed-latency build.
REQ-034 Without SEQ_MUL_EARLY_EXIT_EN, RUN SHALL always last WIDTH cycles and no barrel shifter SHALL exist.

Verification
REQ-035 WIDTH=8, in1=0xFF, in2=0xFF, out_ready=1 -> out=0xFE01 with out_valid high on cycle 9 after accept; in_ready low throughout.
REQ-036 WIDTH=8, in1=0x0D, in2=0x0B, out_ready low for 5 cycles in DONE -> out=0x008F stable all 5 cycles, then IDLE 1 cycle after the out_ready pulse.
REQ-037 WIDTH=8, rst pulse on RUN cycle 4 of 0xAA*0x55 -> next cycle IDLE, out=0, out_valid=0; a following 0x03*0x05 gives 0x000F.
REQ-038 WIDTH=8, in_valid held high with changing operands during a busy operation -> only the first pair is processed; the next accept occurs in the IDLE cycle.
REQ-039 SEQ_MUL_EARLY_EXIT_EN defined, WIDTH=8: in2=0x01, in1=0xC3 -> out=0x00C3 after 1 RUN cycle; in2=0x00 -> out=0 after 1 RUN cycle; in2=0x80 -> 8 RUN cycles.
REQ-040 Random regression, WIDTH=4/8/16, 10k pairs with random handshake stalls -> every out equals the in1*in2 reference model, in both macro builds.
